// File: rtl/adp_types.sv
// Shared types and address-map constants for the ADP debug bridge.
package adp_types;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} adp_bridge_state_t;
  typedef enum logic [1:0] {SEC_SRAM, SEC_REG, SEC_CORE, SEC_ERR} adp_section_t;

  localparam int ADP_BRIDGE_TIMEOUT = 16;

  // addr[15:13] selects the section; the remaining bits must fit the section's window.
  localparam logic [2:0] SRAM_ADDR_TAG = 3'b001;
  localparam logic [2:0] REG_ADDR_TAG  = 3'b010;
  localparam logic [2:0] CORE_ADDR_TAG = 3'b100;

  localparam logic [1:0] CORE_PC_ADDR  = 2'h0;
  localparam logic [1:0] CORE_IR_ADDR  = 2'h1;
  localparam logic [1:0] CORE_ADC_ADDR = 2'h2;
  localparam logic [1:0] CORE_DAC_ADDR = 2'h3;

endpackage

// File: rtl/adp_addr_decode.sv
// Combinational address and permission decode for debug requests.
module adp_addr_decode
  import adp_types::*;
(
  input  logic [15:0]  addr,
  input  logic         write,
  output adp_section_t section,
  output logic [12:0]  offset,
  output logic         err
);

  always_comb begin
    section = SEC_ERR;
    offset  = '0;
    if (addr[15:13] == SRAM_ADDR_TAG) begin
      section = SEC_SRAM;
      offset  = addr[12:0];
    end else if (addr[15:13] == REG_ADDR_TAG && addr[12:5] == 8'h00) begin
      section = SEC_REG;
      offset  = {8'h00, addr[4:0]};
    end else if (addr[15:13] == CORE_ADDR_TAG && addr[12:2] == 11'h000) begin
      section = SEC_CORE;
      offset  = {11'h000, addr[1:0]};
    end
    // Only the DAC is writable in the core window.
    err = (section == SEC_ERR) ||
          (section == SEC_CORE && write && addr[1:0] != CORE_DAC_ADDR);
  end

endmodule

// File: rtl/adp_debug_bridge.sv
// Bridges TAP debug read/write requests onto the SRAM, register and core-status buses.
// Handshakes: a transfer happens on a clock edge where valid and ready are both high; valid holds its payload until then.
module adp_debug_bridge
  import adp_types::*;
#(
  parameter int TIMEOUT_CYCLES = ADP_BRIDGE_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [15:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              sram_en,
  output logic              sram_we,
  output logic [12:0]       sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  input  logic              sram_ready,
  output logic              reg_en,
  output logic              reg_we,
  output logic [4:0]        reg_addr,
  output logic [31:0]       reg_wdata,
  input  logic [31:0]       reg_rdata,
  output logic              core_en,
  output logic              core_we,
  output logic [1:0]        core_addr,
  output logic [31:0]       core_wdata,
  input  logic [31:0]       core_rdata,
  output adp_bridge_state_t dbg_state
);

  localparam logic [4:0] TO_LAST = 5'(TIMEOUT_CYCLES - 1);

  adp_bridge_state_t state, state_n;
  adp_section_t      dec_sec, lat_sec, lat_sec_n;
  logic [12:0]       dec_off;
  logic              dec_err;
  logic [4:0]        cnt, cnt_n;
  logic              pend, pend_n, lat_write, lat_write_n;
  logic              sram_en_n, sram_we_n, reg_en_n, reg_we_n, core_en_n, core_we_n;
  logic [12:0]       sram_addr_n;
  logic [4:0]        reg_addr_n;
  logic [1:0]        core_addr_n;
  logic [31:0]       sram_wdata_n, reg_wdata_n, core_wdata_n, rsp_rdata_n;
  logic              rsp_valid_n, rsp_err_n;

  adp_addr_decode u_decode (
    .addr    (req_addr),
    .write   (req_write),
    .section (dec_sec),
    .offset  (dec_off),
    .err     (dec_err)
  );

  assign req_ready = (state == IDLE);
  assign dbg_state = state;

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    pend_n       = pend;
    lat_write_n  = lat_write;
    lat_sec_n    = lat_sec;
    sram_en_n    = sram_en;
    sram_we_n    = sram_we;
    sram_addr_n  = sram_addr;
    sram_wdata_n = sram_wdata;
    reg_en_n     = reg_en;
    reg_we_n     = reg_we;
    reg_addr_n   = reg_addr;
    reg_wdata_n  = reg_wdata;
    core_en_n    = core_en;
    core_we_n    = core_we;
    core_addr_n  = core_addr;
    core_wdata_n = core_wdata;
    rsp_valid_n  = rsp_valid;
    rsp_rdata_n  = rsp_rdata;
    rsp_err_n    = rsp_err;
    case (state)
      IDLE: if (req_valid) begin
        lat_write_n = req_write;
        lat_sec_n   = dec_sec;
        if (dec_err || dec_sec == SEC_ERR) begin
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          rsp_rdata_n = '0;
          state_n     = RESP;
        end else if (dec_sec == SEC_SRAM) begin
          sram_en_n    = 1'b1;
          sram_we_n    = req_write;
          sram_addr_n  = dec_off;
          sram_wdata_n = req_wdata;
          cnt_n        = '0;
          state_n      = WAIT;
        end else if (dec_sec == SEC_REG) begin
          reg_en_n    = 1'b1;
          reg_we_n    = req_write;
          reg_addr_n  = dec_off[4:0];
          reg_wdata_n = req_wdata;
          state_n     = ACCESS;
        end else begin
          core_en_n    = 1'b1;
          core_we_n    = req_write;
          core_addr_n  = dec_off[1:0];
          core_wdata_n = req_wdata;
          state_n      = ACCESS;
        end
      end
      ACCESS: begin
        reg_en_n  = 1'b0;
        reg_we_n  = 1'b0;
        core_en_n = 1'b0;
        core_we_n = 1'b0;
        pend_n    = 1'b1;
        state_n   = RESP;
      end
      WAIT: begin
        // A ready that coincides with the last timeout cycle still wins.
        if (sram_ready) begin
          sram_en_n   = 1'b0;
          sram_we_n   = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b0;
          rsp_rdata_n = lat_write ? 32'h0 : sram_rdata;
          state_n     = RESP;
        end else if (cnt == TO_LAST) begin
          sram_en_n   = 1'b0;
          sram_we_n   = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          rsp_rdata_n = '0;
          state_n     = RESP;
        end else if (cnt != 5'h1F) begin
          cnt_n = cnt + 5'd1;
        end
      end
      RESP: begin
        // Target read data lands the cycle after the enable pulse, i.e. in the first RESP cycle.
        if (pend) begin
          pend_n      = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b0;
          rsp_rdata_n = lat_write ? 32'h0 : (lat_sec == SEC_CORE ? core_rdata : reg_rdata);
        end else if (rsp_valid && rsp_ready) begin
          rsp_valid_n = 1'b0;
          rsp_err_n   = 1'b0;
          rsp_rdata_n = '0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pend       <= 1'b0;
      lat_write  <= 1'b0;
      lat_sec    <= SEC_ERR;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      reg_en     <= 1'b0;
      reg_we     <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      core_en    <= 1'b0;
      core_we    <= 1'b0;
      core_addr  <= '0;
      core_wdata <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pend       <= pend_n;
      lat_write  <= lat_write_n;
      lat_sec    <= lat_sec_n;
      sram_en    <= sram_en_n;
      sram_we    <= sram_we_n;
      sram_addr  <= sram_addr_n;
      sram_wdata <= sram_wdata_n;
      reg_en     <= reg_en_n;
      reg_we     <= reg_we_n;
      reg_addr   <= reg_addr_n;
      reg_wdata  <= reg_wdata_n;
      core_en    <= core_en_n;
      core_we    <= core_we_n;
      core_addr  <= core_addr_n;
      core_wdata <= core_wdata_n;
      rsp_valid  <= rsp_valid_n;
      rsp_rdata  <= rsp_rdata_n;
      rsp_err    <= rsp_err_n;
    end
  end

endmodule

// File: tb/tb_adp_debug_bridge.sv
// Self-checking bench for adp_debug_bridge with simple SRAM/register/core target models.
module tb_adp_debug_bridge;
  import adp_types::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic rsp_ready = 1'b0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic sram_en, sram_we, reg_en, reg_we, core_en, core_we;
  logic [12:0] sram_addr;
  logic [4:0] reg_addr;
  logic [1:0] core_addr;
  logic [31:0] sram_wdata, reg_wdata, core_wdata;
  logic [31:0] sram_rdata = '0, reg_rdata = '0, core_rdata = '0;
  logic sram_ready = 1'b0;
  adp_bridge_state_t dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];

  // target model state / observation
  int sram_delay = 0;
  logic [31:0] sram_val = '0;
  int s_cnt = 0;
  int sram_en_cnt = 0, reg_en_cnt = 0, core_en_cnt = 0;
  logic [12:0] m_sram_addr;
  logic m_sram_we, m_reg_we, m_core_we;
  logic [4:0] m_reg_addr;
  logic [1:0] m_core_addr;
  logic [31:0] m_reg_wdata, m_core_wdata;
  logic r_hit = 1'b0, c_hit = 1'b0;
  logic [4:0] r_a = '0;
  logic [1:0] c_a = '0;

  adp_debug_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .reg_en(reg_en), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata),
    .core_en(core_en), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Monitor plus SRAM responder, evaluated mid-cycle.
  always @(negedge clk) begin
    if (sram_en) begin
      sram_en_cnt++;
      m_sram_addr = sram_addr;
      m_sram_we = sram_we;
      s_cnt++;
      sram_ready = (s_cnt == sram_delay);
    end else begin
      s_cnt = 0;
      sram_ready = 1'b0;
    end
    sram_rdata = sram_ready ? sram_val : 32'h0BAD_F00D;
    if (reg_en) begin
      reg_en_cnt++;
      m_reg_addr = reg_addr;
      m_reg_we = reg_we;
      m_reg_wdata = reg_wdata;
    end
    if (core_en) begin
      core_en_cnt++;
      m_core_addr = core_addr;
      m_core_we = core_we;
      m_core_wdata = core_wdata;
    end
    r_hit = reg_en;
    r_a = reg_addr;
    c_hit = core_en;
    c_a = core_addr;
  end

  // Register/core targets: read data valid for the whole cycle after the enable.
  always @(posedge clk) begin
    #1;
    reg_rdata = r_hit ? (32'hA500_0000 | {27'h0, r_a}) : 32'hDEAD_0000;
    core_rdata = c_hit ? (32'hC0DE_0000 | {30'h0, c_a}) : 32'hDEAD_0001;
  end

  task automatic clear_mon();
    sram_en_cnt = 0;
    reg_en_cnt = 0;
    core_en_cnt = 0;
  endtask

  // driver: one request, response checked against the scoreboard
  task automatic do_req(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd,
                        input int exp_lat, input int hold, input string name);
    int lat;
    logic [32:0] got, exp;
    clear_mon();
    exp_q.push_back({exp_err, exp_rd});
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s req_ready_idle: got %b exp 1", name, req_ready);
    end
    req_valid = 1'b1;
    req_write = wr;
    req_addr = a;
    req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    exp = exp_q.pop_front();
    n_vec++;
    if (rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s rsp_timeout: no rsp_valid within %0d cycles", name, lat);
      return;
    end
    if (lat != exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d exp %0d", name, lat, exp_lat);
    end
    got = {rsp_err, rsp_rdata};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s rsp: got err=%b rdata=%h exp err=%b rdata=%h",
               name, got[32], got[31:0], exp[32], exp[31:0]);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_vec++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, got} || req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s backpressure_c%0d: got v=%b err=%b rd=%h rr=%b exp v=1 err=%b rd=%h rr=0",
                 name, i, rsp_valid, rsp_err, rsp_rdata, req_ready, got[32], got[31:0]);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s release: got rsp_valid=%b req_ready=%b exp 0/1", name, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 ||
        {sram_en, sram_we, reg_en, reg_we, core_en, core_we} !== 6'b0 ||
        sram_addr !== 13'h0 || reg_addr !== 5'h0 || core_addr !== 2'h0 ||
        sram_wdata !== 32'h0 || reg_wdata !== 32'h0 || core_wdata !== 32'h0 || dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_state: rr=%b rv=%b err=%b rd=%h en=%b st=%0d exp rr=1 others 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata,
               {sram_en, sram_we, reg_en, reg_we, core_en, core_we}, dbg_state);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sram_read();
    sram_delay = 3;
    sram_val = 32'hDEAD_BEEF;
    do_req(1'b0, 16'h2005, 32'h0, 1'b0, 32'hDEAD_BEEF, 4, 0, "sram_rd_2005");
    n_vec++;
    if (m_sram_addr !== 13'h0005 || m_sram_we !== 1'b0 || sram_en_cnt != 3) begin
      n_err++;
      $display("FAIL sram_rd_bus: got addr=%h we=%b en_cycles=%0d exp 0005/0/3",
               m_sram_addr, m_sram_we, sram_en_cnt);
    end
  endtask

  task automatic test_reg();
    do_req(1'b1, 16'h401F, 32'h1234_5678, 1'b0, 32'h0, 3, 0, "reg_wr_401f");
    n_vec++;
    if (reg_en_cnt != 1 || m_reg_we !== 1'b1 || m_reg_addr !== 5'h1F || m_reg_wdata !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL reg_wr_bus: got en_cycles=%0d we=%b addr=%h wd=%h exp 1/1/1f/12345678",
               reg_en_cnt, m_reg_we, m_reg_addr, m_reg_wdata);
    end
    do_req(1'b0, 16'h4007, 32'h0, 1'b0, 32'hA500_0007, 3, 0, "reg_rd_4007");
  endtask

  task automatic test_decode_err();
    logic [15:0] bad[3];
    bad[0] = 16'h1000;
    bad[1] = 16'h4020;
    bad[2] = 16'hA000;
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, bad[i], 32'h0, 1'b1, 32'h0, 1, 0, "decode_err");
      n_vec++;
      if (sram_en_cnt + reg_en_cnt + core_en_cnt != 0) begin
        n_err++;
        $display("FAIL decode_err_en addr=%h: got %0d enable cycles exp 0", bad[i], sram_en_cnt + reg_en_cnt + core_en_cnt);
      end
    end
  endtask

  task automatic test_core();
    logic [31:0] wd;
    wd = $urandom_range(32'h7FFF_FFFF, 0);
    do_req(1'b1, 16'h8000, wd, 1'b1, 32'h0, 1, 0, "core_wr_pc");
    n_vec++;
    if (core_en_cnt != 0) begin
      n_err++;
      $display("FAIL core_wr_pc_en: got %0d core_en cycles exp 0", core_en_cnt);
    end
    do_req(1'b1, 16'h8003, wd, 1'b0, 32'h0, 3, 0, "core_wr_dac");
    n_vec++;
    if (core_en_cnt != 1 || m_core_we !== 1'b1 || m_core_addr !== 2'h3 || m_core_wdata !== wd) begin
      n_err++;
      $display("FAIL core_wr_dac_bus: got en_cycles=%0d we=%b addr=%h wd=%h exp 1/1/3/%h",
               core_en_cnt, m_core_we, m_core_addr, m_core_wdata, wd);
    end
    do_req(1'b0, 16'h8001, 32'h0, 1'b0, 32'hC0DE_0001, 3, 0, "core_rd_ir");
  endtask

  task automatic test_timeout();
    sram_delay = 0;
    do_req(1'b0, 16'h2100, 32'h0, 1'b1, 32'h0, 17, 0, "sram_timeout");
    n_vec++;
    if (sram_en_cnt != 16) begin
      n_err++;
      $display("FAIL sram_timeout_en: got %0d sram_en cycles exp 16", sram_en_cnt);
    end
    sram_delay = 16;
    sram_val = 32'h5A5A_1616;
    do_req(1'b0, 16'h3FFF, 32'h0, 1'b0, 32'h5A5A_1616, 17, 0, "sram_ready_c16");
    sram_delay = 2;
    do_req(1'b1, 16'h2ABC, 32'hCAFE_0001, 1'b0, 32'h0, 3, 0, "sram_wr");
    n_vec++;
    if (m_sram_we !== 1'b1 || m_sram_addr !== 13'h0ABC) begin
      n_err++;
      $display("FAIL sram_wr_bus: got we=%b addr=%h exp 1/0abc", m_sram_we, m_sram_addr);
    end
  endtask

  task automatic test_back_to_back();
    do_req(1'b0, 16'h4003, 32'h0, 1'b0, 32'hA500_0003, 3, 5, "backpressure");
    for (int i = 0; i < 6; i++) begin
      logic [12:0] off;
      off = 13'($urandom_range(8191, 0));
      sram_delay = $urandom_range(8, 1);
      sram_val = $urandom();
      do_req(1'b0, {3'b001, off}, 32'h0, 1'b0, sram_val, sram_delay + 1, $urandom_range(2, 0), "sram_rand");
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    sram_delay = 0;
    clear_mon();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 16'h2010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (dbg_state !== WAIT || sram_en !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_pre: got state=%0d sram_en=%b exp WAIT/1", dbg_state, sram_en);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++;
    if (dbg_state !== IDLE || {sram_en, reg_en, core_en} !== 3'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_idle: got state=%0d en=%b rr=%b rv=%b exp IDLE/000/1/0",
               dbg_state, {sram_en, reg_en, core_en}, req_ready, rsp_valid);
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid === 1'b1 || sram_en === 1'b1) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL reset_mid_quiet: got %0d cycles with rsp_valid/sram_en exp 0", seen);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sram_read();
    test_reg();
    test_decode_err();
    test_core();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
